// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: pairs sensor bytes into RGB565 words, crops the
// frame to X_SIZE x Y_SIZE and pushes the kept words into the frame cache.
// Handshake: CACHE_WREQ is a one-cycle strobe with CACHE_WDATA valid in the
// same cycle; a word is only offered when CACHE_FULL was low in the cycle the
// word sat in the holding register, otherwise it is dropped and OVERFLOW sticks.
module ov7670_capture #(
    parameter int X_SIZE      = 240,
    parameter int Y_SIZE      = 320,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        CLK_PCLK,
    input  logic        RST,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic [7:0]  CAM_DATA,
    input  logic        CACHE_FULL,
    output logic        CACHE_WREQ,
    output logic [15:0] CACHE_WDATA,
    output logic        CACHE_WRST,
    output logic        CACHE_WCLK,
    output logic        FRAME_DONE,
    output logic        OVERFLOW,
    output logic        CAPTURE_BUSY
);

    localparam int PW = $clog2(X_SIZE + 1);
    localparam int LW = $clog2(Y_SIZE + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);

    typedef enum logic [1:0] {
        S_SKIP    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t         state_q;
    logic [SW-1:0]  skip_cnt_q;
    logic [LW-1:0]  line_cnt_q;
    logic [PW-1:0]  pixel_cnt_q;
    logic           phase_q;
    logic [7:0]     hi_byte_q;
    logic [15:0]    word_q;
    logic           word_vld_q;
    logic           wreq_q;
    logic [15:0]    wdata_q;
    logic           wrst_q;
    logic           done_pend_q;
    logic           done_q;
    logic           ovf_q;
    logic           busy_q;

    logic           s1_vsync_q;
    logic           s1_href_q;
    logic [7:0]     s1_data_q;
    logic           s2_vsync_q;
    logic           s2_href_q;

    logic           vsync_rise;
    logic           vsync_fall;
    logic           href_fall;
    logic           in_window;

    // Two-stage input registers; edges compare stage 1 against stage 2.
    always_ff @(posedge CLK_PCLK) begin
        if (RST) begin
            s1_vsync_q <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_data_q  <= 8'h00;
            s2_vsync_q <= 1'b0;
            s2_href_q  <= 1'b0;
        end else begin
            s1_vsync_q <= CAM_VSYNC;
            s1_href_q  <= CAM_HREF;
            s1_data_q  <= CAM_DATA;
            s2_vsync_q <= s1_vsync_q;
            s2_href_q  <= s1_href_q;
        end
    end

    assign vsync_rise = s1_vsync_q & ~s2_vsync_q;
    assign vsync_fall = ~s1_vsync_q & s2_vsync_q;
    assign href_fall  = ~s1_href_q & s2_href_q;
    assign in_window  = (pixel_cnt_q < PW'(X_SIZE)) && (line_cnt_q < LW'(Y_SIZE));

    // Frame FSM, byte pairing and the write stage; the write stage drains the
    // holding register regardless of state so a word formed at frame end lands
    // before the (one cycle later) FRAME_DONE pulse.
    always_ff @(posedge CLK_PCLK) begin
        if (RST) begin
            state_q     <= S_SKIP;
            skip_cnt_q  <= '0;
            line_cnt_q  <= '0;
            pixel_cnt_q <= '0;
            phase_q     <= 1'b0;
            hi_byte_q   <= 8'h00;
            word_q      <= 16'h0000;
            word_vld_q  <= 1'b0;
            wreq_q      <= 1'b0;
            wdata_q     <= 16'h0000;
            wrst_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wrst_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= done_pend_q;
            word_vld_q  <= 1'b0;
            wreq_q      <= 1'b0;

            if (word_vld_q) begin
                if (!CACHE_FULL) begin
                    wreq_q  <= 1'b1;
                    wdata_q <= word_q;
                end else begin
                    ovf_q <= 1'b1;
                end
            end

            case (state_q)
                S_SKIP: begin
                    // The first rise only marks a boundary, hence SKIP_FRAMES+1 rises.
                    if (vsync_rise) begin
                        if (skip_cnt_q == SW'(SKIP_FRAMES)) begin
                            state_q <= S_WAIT;
                        end else begin
                            skip_cnt_q <= skip_cnt_q + SW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (vsync_fall) begin
                        wrst_q      <= 1'b1;
                        line_cnt_q  <= '0;
                        pixel_cnt_q <= '0;
                        phase_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (vsync_rise) begin
                        done_pend_q <= 1'b1;
                        busy_q      <= 1'b0;
                        phase_q     <= 1'b0;
                        state_q     <= S_WAIT;
                    end else if (href_fall) begin
                        if (line_cnt_q < LW'(Y_SIZE)) begin
                            line_cnt_q <= line_cnt_q + LW'(1);
                        end
                        pixel_cnt_q <= '0;
                        phase_q     <= 1'b0;
                    end else if (s1_href_q) begin
                        if (!phase_q) begin
                            hi_byte_q <= s1_data_q;
                            phase_q   <= 1'b1;
                        end else begin
                            phase_q    <= 1'b0;
                            word_q     <= {hi_byte_q, s1_data_q};
                            word_vld_q <= in_window;
                            if (pixel_cnt_q < PW'(X_SIZE)) begin
                                pixel_cnt_q <= pixel_cnt_q + PW'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_SKIP;
            endcase
        end
    end

    assign CACHE_WREQ   = wreq_q;
    assign CACHE_WDATA  = wdata_q;
    assign CACHE_WRST   = wrst_q;
    assign FRAME_DONE   = done_q;
    assign OVERFLOW     = ovf_q;
    assign CAPTURE_BUSY = busy_q;
    assign CACHE_WCLK   = ~CLK_PCLK;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: directed frames with a cycle-accurate expectation
// model built from frame/line/pixel arithmetic, plus hand-computed milestones.
module tb_ov7670_capture;

    localparam int X    = 4;
    localparam int Y    = 2;
    localparam int SKIP = 2;
    localparam int MAXC = 1 << 30;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        CAM_VSYNC = 1'b0;
    logic        CAM_HREF = 1'b0;
    logic [7:0]  CAM_DATA = 8'h00;
    logic        CACHE_FULL = 1'b0;
    logic        CACHE_WREQ;
    logic [15:0] CACHE_WDATA;
    logic        CACHE_WRST;
    logic        CACHE_WCLK;
    logic        FRAME_DONE;
    logic        OVERFLOW;
    logic        CAPTURE_BUSY;

    always #5 clk = ~clk;

    ov7670_capture #(.X_SIZE(X), .Y_SIZE(Y), .SKIP_FRAMES(SKIP)) dut (
        .CLK_PCLK    (clk),
        .RST         (RST),
        .CAM_VSYNC   (CAM_VSYNC),
        .CAM_HREF    (CAM_HREF),
        .CAM_DATA    (CAM_DATA),
        .CACHE_FULL  (CACHE_FULL),
        .CACHE_WREQ  (CACHE_WREQ),
        .CACHE_WDATA (CACHE_WDATA),
        .CACHE_WRST  (CACHE_WRST),
        .CACHE_WCLK  (CACHE_WCLK),
        .FRAME_DONE  (FRAME_DONE),
        .OVERFLOW    (OVERFLOW),
        .CAPTURE_BUSY(CAPTURE_BUSY)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Model state: frame bookkeeping and scheduled output events (by cycle).
    int capturing = 0;
    int pulses = 0;
    int line_idx = 0;
    int full_cyc = -1;
    int wq_cyc[$];
    logic [15:0] exp_q[$];
    int wrst_sched[$];
    int done_sched[$];
    int busy_from = MAXC, busy_to = MAXC;
    int ovf_from = MAXC, ovf_to = MAXC;
    int rst_at = -1;
    logic [15:0] exp_wdata = 16'h0000;
    bit chk_en = 1'b0;

    // Observed activity for milestone checks.
    int wreq_cnt = 0, wrst_cnt = 0, done_cnt = 0;
    logic [15:0] words[$];

    logic ew, er, ed, eo, eb;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk);
        #1;
        cyc++;
        RST = r;
        CAM_VSYNC = vs;
        CAM_HREF = hr;
        CAM_DATA = d;
        CACHE_FULL = (cyc == full_cyc);
    endtask

    // VSYNC pulse: 3 cycles high then low, followed by 4 idle cycles.
    task automatic pulse();
        int v;
        int f;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        v = cyc;
        if (capturing != 0) begin
            done_sched.push_back(v + 3);
            busy_to = v + 1;
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        f = cyc;
        pulses++;
        if (pulses >= SKIP + 1) begin
            capturing = 1;
            wrst_sched.push_back(f + 2);
            busy_from = f + 2;
            busy_to = MAXC;
        end else begin
            capturing = 0;
        end
        line_idx = 0;
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // One HREF line of bytes 1..nbytes; full_pix >= 0 holds CACHE_FULL while that pixel is pending.
    task automatic line(input int nbytes, input int gap, input int full_pix);
        int k;
        full_cyc = (full_pix >= 0) ? cyc + 2 * full_pix + 4 : -1;
        for (int b = 0; b < nbytes; b++) begin
            step(1'b0, 1'b0, 1'b1, 8'(b + 1));
            k = cyc;
            if ((b % 2 == 1) && (capturing != 0) && (line_idx < Y) && (b / 2 < X)) begin
                if (k + 2 == full_cyc) begin
                    if (!((k + 3 >= ovf_from) && (k + 3 <= ovf_to))) begin
                        ovf_from = k + 3;
                        ovf_to = MAXC;
                    end
                end else begin
                    wq_cyc.push_back(k + 3);
                    exp_q.push_back({8'(b), 8'(b + 1)});
                end
            end
        end
        repeat (gap) step(1'b0, 1'b0, 1'b0, 8'h00);
        line_idx++;
    endtask

    task automatic frame(input int nlines, input int nbytes, input int last_gap, input int full_pix0);
        for (int l = 0; l < nlines; l++) begin
            line(nbytes, (l == nlines - 1) ? last_gap : 4, (l == 0) ? full_pix0 : -1);
        end
    endtask

    task automatic reset_pulse();
        int r;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        r = cyc;
        while (wq_cyc.size() > 0 && wq_cyc[$] > r) begin
            void'(wq_cyc.pop_back());
            void'(exp_q.pop_back());
        end
        while (wrst_sched.size() > 0 && wrst_sched[$] > r) void'(wrst_sched.pop_back());
        while (done_sched.size() > 0 && done_sched[$] > r) void'(done_sched.pop_back());
        if (busy_to > r) busy_to = r;
        if (ovf_to > r) ovf_to = r;
        rst_at = r + 1;
        capturing = 0;
        pulses = 0;
        line_idx = 0;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_at) exp_wdata = 16'h0000;
            ew = 1'b0;
            if (wq_cyc.size() > 0 && wq_cyc[0] == cyc) begin
                ew = 1'b1;
                exp_wdata = exp_q[0];
                void'(wq_cyc.pop_front());
                void'(exp_q.pop_front());
            end
            er = 1'b0;
            if (wrst_sched.size() > 0 && wrst_sched[0] == cyc) begin
                er = 1'b1;
                void'(wrst_sched.pop_front());
            end
            ed = 1'b0;
            if (done_sched.size() > 0 && done_sched[0] == cyc) begin
                ed = 1'b1;
                void'(done_sched.pop_front());
            end
            eo = (cyc >= ovf_from) && (cyc <= ovf_to);
            eb = (cyc >= busy_from) && (cyc <= busy_to);
            chk("wreq", 16'(CACHE_WREQ), 16'(ew));
            chk("wdata", CACHE_WDATA, exp_wdata);
            chk("wrst", 16'(CACHE_WRST), 16'(er));
            chk("frame_done", 16'(FRAME_DONE), 16'(ed));
            chk("overflow", 16'(OVERFLOW), 16'(eo));
            chk("busy", 16'(CAPTURE_BUSY), 16'(eb));
            if (CACHE_WREQ) begin
                wreq_cnt++;
                words.push_back(CACHE_WDATA);
            end
            if (CACHE_WRST) wrst_cnt++;
            if (FRAME_DONE) done_cnt++;
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_wreq", 16'(CACHE_WREQ), 16'h0000);
        chk("rst_wdata", CACHE_WDATA, 16'h0000);
        chk("rst_wrst", 16'(CACHE_WRST), 16'h0000);
        chk("rst_done", 16'(FRAME_DONE), 16'h0000);
        chk("rst_ovf", 16'(OVERFLOW), 16'h0000);
        chk("rst_busy", 16'(CAPTURE_BUSY), 16'h0000);
        chk_en = 1'b1;

        // Skipped frames A and B.
        pulse();
        frame(2, 8, 4, -1);
        pulse();
        frame(2, 8, 4, -1);
        chk("skip_wreq_cnt", 16'(wreq_cnt), 16'd0);
        chk("skip_wrst_cnt", 16'(wrst_cnt), 16'd0);
        pulse();
        chk("first_wrst_cnt", 16'(wrst_cnt), 16'd1);

        // Frame C: first captured frame.
        frame(2, 8, 4, -1);
        pulse();
        chk("c_wreq_cnt", 16'(wreq_cnt), 16'd8);
        chk("c_done_cnt", 16'(done_cnt), 16'd1);
        chk("c_word0", words[0], 16'h0102);
        chk("c_word3", words[3], 16'h0708);
        chk("c_word4", words[4], 16'h0102);
        chk("c_word7", words[7], 16'h0708);

        // Frame D: cropping.
        frame(3, 12, 4, -1);
        pulse();
        chk("d_wreq_cnt", 16'(wreq_cnt), 16'd16);
        chk("d_ovf", 16'(OVERFLOW), 16'h0000);
        chk("d_done_cnt", 16'(done_cnt), 16'd2);

        // Frame E: backpressure on third word of line 0.
        frame(2, 8, 4, 2);
        pulse();
        chk("e_wreq_cnt", 16'(wreq_cnt), 16'd23);
        chk("e_ovf", 16'(OVERFLOW), 16'h0001);
        chk("e_word18", words[18], 16'h0708);
        chk("e_word19", words[19], 16'h0102);

        // Frame F: odd byte, short frame, VSYNC right after the line.
        frame(1, 7, 0, -1);
        pulse();
        chk("f_wreq_cnt", 16'(wreq_cnt), 16'd26);
        chk("f_done_cnt", 16'(done_cnt), 16'd4);
        chk("f_word25", words[25], 16'h0506);
        chk("f_ovf", 16'(OVERFLOW), 16'h0001);
        chk("f_wrst_cnt", 16'(wrst_cnt), 16'd5);

        // Frame G: reset after 3 bytes.
        line(3, 0, -1);
        reset_pulse();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_wreq", 16'(CACHE_WREQ), 16'h0000);
        chk("mrst_wdata", CACHE_WDATA, 16'h0000);
        chk("mrst_ovf", 16'(OVERFLOW), 16'h0000);
        chk("mrst_busy", 16'(CAPTURE_BUSY), 16'h0000);
        chk("mrst_done", 16'(FRAME_DONE), 16'h0000);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_wreq_cnt", 16'(wreq_cnt), 16'd26);

        // Skip sequence again, then one captured frame ending right at VSYNC.
        pulse();
        frame(2, 8, 4, -1);
        pulse();
        frame(2, 8, 4, -1);
        chk("reskip_wreq_cnt", 16'(wreq_cnt), 16'd26);
        chk("reskip_wrst_cnt", 16'(wrst_cnt), 16'd5);
        pulse();
        chk("recap_wrst_cnt", 16'(wrst_cnt), 16'd6);
        frame(2, 8, 0, -1);
        pulse();
        chk("recap_wreq_cnt", 16'(wreq_cnt), 16'd34);
        chk("recap_done_cnt", 16'(done_cnt), 16'd5);
        chk("recap_last_word", words[33], 16'h0708);

        repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
